// File: rtl/id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_reg
// ID/EX pipeline register of the 5-stage MIPS core. It latches decoded operands
// and control every cycle, supports hold (stall) and bubble insertion (flush),
// forwards EX/MEM and MEM/WB results into the ALU operands, and raises a
// combinational load-use hazard request towards the ID stage.
//
// Build option:
//   ID_EX_FWD_EN  defined   -> forwarding muxes active on both operands.
//                 undefined -> operands taken straight from the latched
//                              register-file data; the hazard output also
//                              interlocks on any pending register write
//                              (full interlock), and the exmem*/memwb*
//                              inputs are ignored.
//
// Ports:
//   clk__i, rst__i               clock (rising edge), async active-high reset
//   stall__i, flush__i           hold contents / insert bubble (flush wins)
//   valid__i                     ID stage holds a real instruction
//   rsData__i, rtData__i, imm__i register-file data and sign-extended imm
//   rsAddr__i, rtAddr__i, rdAddr__i  source/dest register numbers
//   ALUCtrl__i, ALUSrc__i, RegDst__i, RegWrite__i, MemRead__i,
//   MemWrite__i, MemToReg__i     decoded control
//   exmem*__i, memwb*__i         forwarding sources
//   dataA__o, dataB__o           ALU operands
//   storeData__o                 forwarded rt value for stores
//   ALUCtrl__o, writeReg__o      registered ALU op, destination register
//   RegWrite__o, MemRead__o, MemWrite__o, MemToReg__o, valid__o
//   loadUseHazard__o             combinational stall request to ID
// -----------------------------------------------------------------------------
module id_ex_stage_reg #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk__i,
   input  logic                  rst__i,
   input  logic                  stall__i,
   input  logic                  flush__i,
   input  logic                  valid__i,
   input  logic [DATA_W-1:0]     rsData__i,
   input  logic [DATA_W-1:0]     rtData__i,
   input  logic [DATA_W-1:0]     imm__i,
   input  logic [REG_ADDR_W-1:0] rsAddr__i,
   input  logic [REG_ADDR_W-1:0] rtAddr__i,
   input  logic [REG_ADDR_W-1:0] rdAddr__i,
   input  logic [2:0]            ALUCtrl__i,
   input  logic                  ALUSrc__i,
   input  logic                  RegDst__i,
   input  logic                  RegWrite__i,
   input  logic                  MemRead__i,
   input  logic                  MemWrite__i,
   input  logic                  MemToReg__i,
   input  logic                  exmemRegWrite__i,
   input  logic [REG_ADDR_W-1:0] exmemRd__i,
   input  logic [DATA_W-1:0]     exmemResult__i,
   input  logic                  memwbRegWrite__i,
   input  logic [REG_ADDR_W-1:0] memwbRd__i,
   input  logic [DATA_W-1:0]     memwbResult__i,
   output logic [DATA_W-1:0]     dataA__o,
   output logic [DATA_W-1:0]     dataB__o,
   output logic [DATA_W-1:0]     storeData__o,
   output logic [2:0]            ALUCtrl__o,
   output logic [REG_ADDR_W-1:0] writeReg__o,
   output logic                  RegWrite__o,
   output logic                  MemRead__o,
   output logic                  MemWrite__o,
   output logic                  MemToReg__o,
   output logic                  valid__o,
   output logic                  loadUseHazard__o
);

   localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

   // ---------------------------------------------------------------------
   // Stored fields
   // ---------------------------------------------------------------------
   logic                  r_valid;
   logic [DATA_W-1:0]     r_rs_data;
   logic [DATA_W-1:0]     r_rt_data;
   logic [DATA_W-1:0]     r_imm;
   logic [REG_ADDR_W-1:0] r_rs_addr;
   logic [REG_ADDR_W-1:0] r_rt_addr;
   logic [REG_ADDR_W-1:0] r_rd_addr;
   logic [2:0]            r_alu_ctrl;
   logic                  r_alu_src;
   logic                  r_reg_dst;
   logic                  r_reg_write;
   logic                  r_mem_read;
   logic                  r_mem_write;
   logic                  r_mem_to_reg;

   // Priority: reset > flush > stall > load. A bubble only needs its
   // side-effecting control cleared; operand and address fields are left as
   // they were since nothing downstream consumes them while valid is low.
   always_ff @(posedge clk__i or posedge rst__i) begin
      if (rst__i) begin
         r_valid      <= 1'b0;
         r_rs_data    <= '0;
         r_rt_data    <= '0;
         r_imm        <= '0;
         r_rs_addr    <= '0;
         r_rt_addr    <= '0;
         r_rd_addr    <= '0;
         r_alu_ctrl   <= 3'd0;
         r_alu_src    <= 1'b0;
         r_reg_dst    <= 1'b0;
         r_reg_write  <= 1'b0;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_mem_to_reg <= 1'b0;
      end else if (flush__i) begin
         r_valid      <= 1'b0;
         r_alu_ctrl   <= 3'd0;
         r_alu_src    <= 1'b0;
         r_reg_dst    <= 1'b0;
         r_reg_write  <= 1'b0;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_mem_to_reg <= 1'b0;
      end else if (!stall__i) begin
         r_valid      <= valid__i;
         r_rs_data    <= rsData__i;
         r_rt_data    <= rtData__i;
         r_imm        <= imm__i;
         r_rs_addr    <= rsAddr__i;
         r_rt_addr    <= rtAddr__i;
         r_rd_addr    <= rdAddr__i;
         // An empty ID slot must not carry stray control into EX.
         r_alu_ctrl   <= valid__i ? ALUCtrl__i  : 3'd0;
         r_alu_src    <= valid__i & ALUSrc__i;
         r_reg_dst    <= valid__i & RegDst__i;
         r_reg_write  <= valid__i & RegWrite__i;
         r_mem_read   <= valid__i & MemRead__i;
         r_mem_write  <= valid__i & MemWrite__i;
         r_mem_to_reg <= valid__i & MemToReg__i;
      end
   end

   // ---------------------------------------------------------------------
   // Operand selection
   // ---------------------------------------------------------------------
   logic [REG_ADDR_W-1:0] w_write_reg;
   logic [DATA_W-1:0]     w_fwd_a;
   logic [DATA_W-1:0]     w_fwd_b;
   logic                  w_load_use;
   logic                  w_raw_interlock;

   assign w_write_reg = r_reg_dst ? r_rd_addr : r_rt_addr;

`ifdef ID_EX_FWD_EN
   logic w_ex_a_hit;
   logic w_ex_b_hit;
   logic w_wb_a_hit;
   logic w_wb_b_hit;

   // Register 0 is hard-wired to zero, so a write to it is never forwarded.
   assign w_ex_a_hit = exmemRegWrite__i & (exmemRd__i != ZERO_REG) & (exmemRd__i == r_rs_addr);
   assign w_ex_b_hit = exmemRegWrite__i & (exmemRd__i != ZERO_REG) & (exmemRd__i == r_rt_addr);
   assign w_wb_a_hit = memwbRegWrite__i & (memwbRd__i != ZERO_REG) & (memwbRd__i == r_rs_addr);
   assign w_wb_b_hit = memwbRegWrite__i & (memwbRd__i != ZERO_REG) & (memwbRd__i == r_rt_addr);

   // EX/MEM holds the younger result, so it takes precedence over MEM/WB.
   always_comb begin
      w_fwd_a = r_rs_data;
      if (w_ex_a_hit) begin
         w_fwd_a = exmemResult__i;
      end else if (w_wb_a_hit) begin
         w_fwd_a = memwbResult__i;
      end
   end

   always_comb begin
      w_fwd_b = r_rt_data;
      if (w_ex_b_hit) begin
         w_fwd_b = exmemResult__i;
      end else if (w_wb_b_hit) begin
         w_fwd_b = memwbResult__i;
      end
   end

   // With forwarding, only a load's data arrives too late for the next op.
   assign w_raw_interlock = 1'b0;
`else
   logic w_unused_fwd;

   assign w_fwd_a = r_rs_data;
   assign w_fwd_b = r_rt_data;

   // Forwarding sources are not consumed in this build.
   assign w_unused_fwd = ^{exmemRegWrite__i, exmemRd__i, exmemResult__i,
                           memwbRegWrite__i, memwbRd__i, memwbResult__i};

   // Without forwarding, any pending write that the next instruction reads
   // must stall ID until the value lands in the register file.
   assign w_raw_interlock = r_valid & r_reg_write & (w_write_reg != ZERO_REG) &
                            ((w_write_reg == rsAddr__i) | (w_write_reg == rtAddr__i));
`endif

   assign w_load_use = r_valid & r_mem_read & (r_rt_addr != ZERO_REG) &
                       ((r_rt_addr == rsAddr__i) | (r_rt_addr == rtAddr__i));

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign dataA__o         = w_fwd_a;
   assign dataB__o         = r_alu_src ? r_imm : w_fwd_b;
   assign storeData__o     = w_fwd_b;
   assign ALUCtrl__o       = r_alu_ctrl;
   assign writeReg__o      = w_write_reg;
   assign RegWrite__o      = r_reg_write;
   assign MemRead__o       = r_mem_read;
   assign MemWrite__o      = r_mem_write;
   assign MemToReg__o      = r_mem_to_reg;
   assign valid__o         = r_valid;
   assign loadUseHazard__o = w_load_use | w_raw_interlock;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage_reg
// Scoreboard bench for id_ex_stage_reg. The driver applies one stimulus per
// cycle at the falling edge, predicts the outputs visible during that cycle
// from a behavioural model of the stage, and queues the prediction. A
// separate monitor samples the DUT shortly after the falling edge and checks
// it against the head of the queue.
// -----------------------------------------------------------------------------
module tb_id_ex_stage_reg;

   typedef struct {
      logic        rst, stall, flush, valid;
      logic [31:0] rs_d, rt_d, imm;
      logic [4:0]  rs_a, rt_a, rd_a;
      logic [2:0]  alu;
      logic        alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg;
      logic        ex_rw;
      logic [4:0]  ex_rd;
      logic [31:0] ex_res;
      logic        mw_rw;
      logic [4:0]  mw_rd;
      logic [31:0] mw_res;
   } stim_t;

   // Instruction currently held in EX; known=0 after a bubble, when the
   // operand/address fields carry no defined meaning.
   typedef struct {
      logic        valid;
      logic [31:0] rs_d, rt_d, imm;
      logic [4:0]  rs_a, rt_a, rd_a;
      logic [2:0]  alu;
      logic        alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg;
      logic        known;
   } mstate_t;

   typedef struct {
      logic [31:0] a, b, st;
      logic [2:0]  alu;
      logic [4:0]  wr;
      logic        rw, mr, mw, m2r, v, luh, known;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst__i, stall__i, flush__i, valid__i;
   logic [31:0] rsData__i, rtData__i, imm__i;
   logic [4:0]  rsAddr__i, rtAddr__i, rdAddr__i;
   logic [2:0]  ALUCtrl__i;
   logic        ALUSrc__i, RegDst__i, RegWrite__i, MemRead__i, MemWrite__i, MemToReg__i;
   logic        exmemRegWrite__i, memwbRegWrite__i;
   logic [4:0]  exmemRd__i, memwbRd__i;
   logic [31:0] exmemResult__i, memwbResult__i;
   logic [31:0] dataA__o, dataB__o, storeData__o;
   logic [2:0]  ALUCtrl__o;
   logic [4:0]  writeReg__o;
   logic        RegWrite__o, MemRead__o, MemWrite__o, MemToReg__o, valid__o, loadUseHazard__o;

   exp_t    exp_q[$];
   mstate_t m;
   int      vectors     = 0;
   int      miscompares = 0;
   bit      drv_done    = 1'b0;

   always #5 clk = ~clk;

   id_ex_stage_reg #(.DATA_W(32), .REG_ADDR_W(5)) dut (
      .clk__i(clk), .rst__i(rst__i), .stall__i(stall__i), .flush__i(flush__i),
      .valid__i(valid__i), .rsData__i(rsData__i), .rtData__i(rtData__i), .imm__i(imm__i),
      .rsAddr__i(rsAddr__i), .rtAddr__i(rtAddr__i), .rdAddr__i(rdAddr__i),
      .ALUCtrl__i(ALUCtrl__i), .ALUSrc__i(ALUSrc__i), .RegDst__i(RegDst__i),
      .RegWrite__i(RegWrite__i), .MemRead__i(MemRead__i), .MemWrite__i(MemWrite__i),
      .MemToReg__i(MemToReg__i),
      .exmemRegWrite__i(exmemRegWrite__i), .exmemRd__i(exmemRd__i), .exmemResult__i(exmemResult__i),
      .memwbRegWrite__i(memwbRegWrite__i), .memwbRd__i(memwbRd__i), .memwbResult__i(memwbResult__i),
      .dataA__o(dataA__o), .dataB__o(dataB__o), .storeData__o(storeData__o),
      .ALUCtrl__o(ALUCtrl__o), .writeReg__o(writeReg__o), .RegWrite__o(RegWrite__o),
      .MemRead__o(MemRead__o), .MemWrite__o(MemWrite__o), .MemToReg__o(MemToReg__o),
      .valid__o(valid__o), .loadUseHazard__o(loadUseHazard__o)
   );

   // ---------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------
   function automatic mstate_t reset_state();
      mstate_t r;
      r = '{default: '0};
      r.known = 1'b1;
      return r;
   endfunction

   // Value a source register takes once newer pipeline results are considered.
   function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] d, input stim_t s);
`ifdef ID_EX_FWD_EN
      if (a != 0 && s.ex_rw && s.ex_rd == a) return s.ex_res;
      if (a != 0 && s.mw_rw && s.mw_rd == a) return s.mw_res;
`endif
      return d;
   endfunction

   function automatic exp_t predict(input mstate_t st, input stim_t s);
      exp_t e;
      logic [31:0] rt_val;
      logic        next_reads;
      rt_val  = operand(st.rt_a, st.rt_d, s);
      e.a     = operand(st.rs_a, st.rs_d, s);
      e.b     = st.alu_src ? st.imm : rt_val;
      e.st    = rt_val;
      e.alu   = st.alu;
      e.wr    = st.reg_dst ? st.rd_a : st.rt_a;
      e.rw    = st.reg_write;
      e.mr    = st.mem_read;
      e.mw    = st.mem_write;
      e.m2r   = st.mem_to_reg;
      e.v     = st.valid;
      e.known = st.known;
      next_reads = (st.rt_a == s.rs_a) || (st.rt_a == s.rt_a);
      e.luh   = st.valid && st.mem_read && st.rt_a != 0 && next_reads;
`ifndef ID_EX_FWD_EN
      if (st.valid && st.reg_write && e.wr != 0 && (e.wr == s.rs_a || e.wr == s.rt_a))
         e.luh = 1'b1;
`endif
      return e;
   endfunction

   function automatic mstate_t advance(input mstate_t st, input stim_t s);
      mstate_t n;
      n = st;
      if (s.flush) begin
         n.valid = 0; n.alu = 0; n.reg_write = 0; n.mem_read = 0;
         n.mem_write = 0; n.mem_to_reg = 0; n.alu_src = 0; n.reg_dst = 0;
         n.known = 0;
      end else if (!s.stall) begin
         n.valid = s.valid;
         n.rs_d = s.rs_d; n.rt_d = s.rt_d; n.imm = s.imm;
         n.rs_a = s.rs_a; n.rt_a = s.rt_a; n.rd_a = s.rd_a;
         if (s.valid) begin
            n.alu = s.alu; n.alu_src = s.alu_src; n.reg_dst = s.reg_dst;
            n.reg_write = s.reg_write; n.mem_read = s.mem_read;
            n.mem_write = s.mem_write; n.mem_to_reg = s.mem_to_reg;
         end else begin
            n.alu = 0; n.alu_src = 0; n.reg_dst = 0; n.reg_write = 0;
            n.mem_read = 0; n.mem_write = 0; n.mem_to_reg = 0;
         end
         n.known = 1'b1;
      end
      return n;
   endfunction

   // ---------------------------------------------------------------------
   // Driver helpers
   // ---------------------------------------------------------------------
   function automatic stim_t idle();
      stim_t s;
      s = '{default: '0};
      return s;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      logic [2:0] ops [6];
      ops = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
      s.rst        = ($urandom_range(0, 39) == 0);
      s.stall      = ($urandom_range(0, 4) == 0);
      s.flush      = ($urandom_range(0, 6) == 0);
      s.valid      = ($urandom_range(0, 5) != 0);
      s.rs_d       = $urandom;
      s.rt_d       = $urandom;
      s.imm        = $urandom;
      s.rs_a       = 5'($urandom_range(0, 7));
      s.rt_a       = 5'($urandom_range(0, 7));
      s.rd_a       = 5'($urandom_range(0, 7));
      s.alu        = ops[$urandom_range(0, 5)];
      s.alu_src    = 1'($urandom);
      s.reg_dst    = 1'($urandom);
      s.reg_write  = 1'($urandom);
      s.mem_read   = 1'($urandom);
      s.mem_write  = 1'($urandom);
      s.mem_to_reg = 1'($urandom);
      s.ex_rw      = 1'($urandom);
      s.ex_rd      = 5'($urandom_range(0, 7));
      s.ex_res     = $urandom;
      s.mw_rw      = 1'($urandom);
      s.mw_rd      = 5'($urandom_range(0, 7));
      s.mw_res     = $urandom;
      return s;
   endfunction

   task automatic drive(input stim_t s);
      rst__i = s.rst; stall__i = s.stall; flush__i = s.flush; valid__i = s.valid;
      rsData__i = s.rs_d; rtData__i = s.rt_d; imm__i = s.imm;
      rsAddr__i = s.rs_a; rtAddr__i = s.rt_a; rdAddr__i = s.rd_a;
      ALUCtrl__i = s.alu; ALUSrc__i = s.alu_src; RegDst__i = s.reg_dst;
      RegWrite__i = s.reg_write; MemRead__i = s.mem_read;
      MemWrite__i = s.mem_write; MemToReg__i = s.mem_to_reg;
      exmemRegWrite__i = s.ex_rw; exmemRd__i = s.ex_rd; exmemResult__i = s.ex_res;
      memwbRegWrite__i = s.mw_rw; memwbRd__i = s.mw_rd; memwbResult__i = s.mw_res;
   endtask

   // One cycle: drive at the falling edge, queue what this cycle must show,
   // then step the model across the coming rising edge.
   task automatic apply(input stim_t s);
      @(negedge clk);
      drive(s);
      if (s.rst) m = reset_state();
      exp_q.push_back(predict(m, s));
      if (!s.rst) m = advance(m, s);
   endtask

   // ---------------------------------------------------------------------
   // Monitor
   // ---------------------------------------------------------------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      if (act !== req) begin
         miscompares++;
         $display("FAIL vec %0d %s: got %h expected %h", vectors, name, act, req);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            chk("valid",    32'(valid__o),         32'(e.v));
            chk("RegWrite", 32'(RegWrite__o),      32'(e.rw));
            chk("MemRead",  32'(MemRead__o),       32'(e.mr));
            chk("MemWrite", 32'(MemWrite__o),      32'(e.mw));
            chk("MemToReg", 32'(MemToReg__o),      32'(e.m2r));
            chk("ALUCtrl",  32'(ALUCtrl__o),       32'(e.alu));
            chk("loadUse",  32'(loadUseHazard__o), 32'(e.luh));
            if (e.known) begin
               chk("dataA",     dataA__o,          e.a);
               chk("dataB",     dataB__o,          e.b);
               chk("storeData", storeData__o,      e.st);
               chk("writeReg",  32'(writeReg__o),  32'(e.wr));
            end
            $display("vec %0d: v=%b A=%h B=%h st=%h alu=%0d wr=%0d ctl=%b%b%b%b luh=%b",
                     vectors, valid__o, dataA__o, dataB__o, storeData__o, ALUCtrl__o,
                     writeReg__o, RegWrite__o, MemRead__o, MemWrite__o, MemToReg__o,
                     loadUseHazard__o);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   initial begin
      stim_t s;
      m = reset_state();
      s = idle();
      s.rst = 1'b1;
      drive(s);

      // Reset held for two cycles.
      apply(s);
      apply(s);

      // Basic ADD load; rs register 5 so the next cycles can forward into it.
      s = idle();
      s.valid = 1; s.rs_d = 32'h0000_00F0; s.rt_d = 32'h0000_000F; s.alu = 3'd2;
      s.rs_a = 5'd5; s.rt_a = 5'd6; s.rd_a = 5'd7; s.reg_dst = 1; s.reg_write = 1;
      apply(s);

      // Both forward sources target r5 while the stage holds.
      s = idle();
      s.stall = 1; s.rs_a = 5'd9; s.rt_a = 5'd10;
      s.ex_rw = 1; s.ex_rd = 5'd5; s.ex_res = 32'h0000_1234;
      s.mw_rw = 1; s.mw_rd = 5'd5; s.mw_res = 32'h0000_BEEF;
      apply(s);
      s.ex_rw = 0;
      apply(s);
      s.valid = 1; s.rs_d = 32'hAAAA_5555; s.imm = 32'hFFFF_FF80; s.alu_src = 1;
      apply(s);

      // Register 0 is never forwarded.
      s = idle();
      s.valid = 1; s.rs_a = 5'd0; s.rs_d = 32'h0; s.rt_a = 5'd3; s.rt_d = 32'h33;
      s.alu = 3'd6;
      apply(s);
      s = idle();
      s.stall = 1; s.ex_rw = 1; s.ex_rd = 5'd0; s.ex_res = 32'hDEAD_BEEF;
      s.mw_rw = 1; s.mw_rd = 5'd0; s.mw_res = 32'hCAFE_F00D;
      apply(s);

      // Three cycles of stall with changing inputs, then stall+flush.
      for (int i = 0; i < 3; i++) begin
         s = rand_stim();
         s.rst = 0; s.flush = 0; s.stall = 1;
         apply(s);
      end
      s = rand_stim();
      s.rst = 0; s.stall = 1; s.flush = 1;
      apply(s);
      s = idle();
      apply(s);

      // lw r8 in EX, next instruction reads r8, then lw to r0.
      s = idle();
      s.valid = 1; s.mem_read = 1; s.mem_to_reg = 1; s.reg_write = 1;
      s.rs_a = 5'd1; s.rt_a = 5'd8; s.alu = 3'd2; s.alu_src = 1; s.imm = 32'h10;
      apply(s);
      s = idle();
      s.valid = 1; s.rs_a = 5'd8; s.rt_a = 5'd2;
      s.stall = 1; s.flush = 1;
      apply(s);
      s = idle();
      s.valid = 1; s.mem_read = 1; s.reg_write = 1; s.rs_a = 5'd1; s.rt_a = 5'd0;
      apply(s);
      s = idle();
      s.valid = 1; s.rs_a = 5'd0; s.rt_a = 5'd0;
      apply(s);

      // Reset asserted mid-cycle with a valid instruction loaded.
      s = idle();
      s.valid = 1; s.rs_d = 32'h1111_2222; s.rt_d = 32'h3333_4444; s.alu = 3'd7;
      s.rs_a = 5'd4; s.rt_a = 5'd5; s.reg_write = 1; s.mem_write = 1;
      apply(s);
      s.stall = 1; s.rst = 1;
      apply(s);
      s.rst = 0; s.stall = 0; s.valid = 0;
      apply(s);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         apply(rand_stim());
      end

      s = idle();
      apply(s);
      repeat (2) @(negedge clk);
      drv_done = 1'b1;
   end

   initial begin
      wait (drv_done);
      #3;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
